lo_tune_ctrl: RTL and testbench

- Synthesizable tuning controller for the IQ demodulator local-oscillator sine source; drives its frequency input (kHz).
- Accepts retune requests over a valid/ready handshake and slews the LO frequency toward the target in programmable steps, so the mixer never sees a large frequency jump.
- After the slew it waits a fixed settle time, then asserts `locked` so downstream demod logic knows the LO is stable.

---
 rtl/lo_tune_if.sv | 30 +++
 rtl/lo_tune_ctrl.sv | 159 +++++++++++++++
 tb/tb_lo_tune_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lo_tune_if.sv
`default_nettype none
// ============================================================================
// Module   : lo_tune_if
// Brief    : Retune request channel (valid/ready) for the LO tuning controller.
// Revision : 1.0
// ============================================================================
interface lo_tune_if #(
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned STEP_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [FREQ_W-1:0] req_freq;
    logic [STEP_W-1:0] req_step;

    modport master (
        output req_valid,
        output req_freq,
        output req_step,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_freq,
        input  req_step,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/lo_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lo_tune_ctrl
// Brief    : Slews the IQ-demod LO frequency toward retune targets, then
//            asserts lock after a settle period. Optional clamp of requested
//            targets into [FMIN, FMAX] when LO_TUNE_CLAMP_EN is defined.
// Revision : 1.0
// ============================================================================
module lo_tune_ctrl #(
    parameter int unsigned FREQ_W       = 16,
    parameter int unsigned STEP_W       = 12,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned DEFAULT_FREQ = 2000,
    parameter int unsigned FMIN         = 500,
    parameter int unsigned FMAX         = 4000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    lo_tune_if.slave               s_req,
    input  wire logic              i_abort,
    output logic      [FREQ_W-1:0] o_freq_out,
    output logic                   o_freq_upd,
    output logic                   o_busy,
    output logic                   o_locked,
    output logic                   o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAMP   = 2'd1,
        S_SETTLE = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [FREQ_W-1:0] c_default = FREQ_W'(DEFAULT_FREQ);
    localparam logic [7:0]        c_settle  = 8'(SETTLE_CYC);

    state_t            r_state,   w_state_nxt;
    logic [FREQ_W-1:0] r_freq,    w_freq_nxt;
    logic [FREQ_W-1:0] r_target,  w_target_nxt;
    logic [STEP_W-1:0] r_step,    w_step_nxt;
    logic [7:0]        r_cnt,     w_cnt_nxt;
    logic              r_upd,     w_upd_nxt;
    logic              r_cfg_err, w_cfg_err_nxt;

    logic              w_accept;
    logic              w_up;
    logic [FREQ_W:0]   w_dist;
    logic [FREQ_W:0]   w_step_ext;
    logic [FREQ_W-1:0] w_req_freq;
    logic              w_clamp_hit;

`ifdef LO_TUNE_CLAMP_EN
    localparam logic [FREQ_W-1:0] c_fmin = FREQ_W'(FMIN);
    localparam logic [FREQ_W-1:0] c_fmax = FREQ_W'(FMAX);

    always_comb begin
        w_req_freq  = s_req.req_freq;
        w_clamp_hit = 1'b0;
        if (s_req.req_freq < c_fmin) begin
            w_req_freq  = c_fmin;
            w_clamp_hit = 1'b1;
        end else if (s_req.req_freq > c_fmax) begin
            w_req_freq  = c_fmax;
            w_clamp_hit = 1'b1;
        end
    end
`else
    logic w_unused_bounds;
    assign w_unused_bounds = (FMIN > FMAX);
    assign w_req_freq      = s_req.req_freq;
    assign w_clamp_hit     = 1'b0;
`endif

    assign s_req.req_ready = (r_state == S_IDLE) || (r_state == S_LOCKED);
    assign w_accept        = s_req.req_valid && s_req.req_ready;

    // Distance is formed one bit wider so the comparison against the step never wraps.
    assign w_up       = (r_target > r_freq);
    assign w_dist     = w_up ? ({1'b0, r_target} - {1'b0, r_freq})
                             : ({1'b0, r_freq} - {1'b0, r_target});
    assign w_step_ext = (FREQ_W+1)'(r_step);

    always_comb begin
        w_state_nxt   = r_state;
        w_freq_nxt    = r_freq;
        w_target_nxt  = r_target;
        w_step_nxt    = r_step;
        w_cnt_nxt     = r_cnt;
        w_upd_nxt     = 1'b0;
        w_cfg_err_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_LOCKED: begin
                if (w_accept) begin
                    w_target_nxt  = w_req_freq;
                    w_step_nxt    = s_req.req_step;
                    w_cfg_err_nxt = w_clamp_hit;
                    w_state_nxt   = S_RAMP;
                end
            end
            S_RAMP: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_freq == r_target) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_SETTLE;
                end else if ((r_step == '0) || (w_dist <= w_step_ext)) begin
                    w_freq_nxt  = r_target;
                    w_upd_nxt   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_SETTLE;
                end else begin
                    // Distance exceeds the step here, so neither direction can wrap.
                    w_freq_nxt = w_up ? (r_freq + FREQ_W'(r_step))
                                      : (r_freq - FREQ_W'(r_step));
                    w_upd_nxt  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_settle) begin
                    w_state_nxt = S_LOCKED;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_freq    <= c_default;
            r_target  <= c_default;
            r_step    <= '0;
            r_cnt     <= 8'd0;
            r_upd     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_freq    <= w_freq_nxt;
            r_target  <= w_target_nxt;
            r_step    <= w_step_nxt;
            r_cnt     <= w_cnt_nxt;
            r_upd     <= w_upd_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    assign o_freq_out = r_freq;
    assign o_freq_upd = r_upd;
    assign o_busy     = (r_state == S_RAMP) || (r_state == S_SETTLE);
    assign o_locked   = (r_state == S_LOCKED);
    assign o_cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_lo_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lo_tune_ctrl
// Brief    : Directed and randomized retune sequences against a closed-form
//            trajectory model of the LO tuning controller.
// Revision : 1.0
// ============================================================================
module tb_lo_tune_ctrl;

    localparam int FREQ_W       = 16;
    localparam int STEP_W       = 12;
    localparam int SETTLE_CYC   = 16;
    localparam int DEFAULT_FREQ = 2000;
    localparam int FMIN         = 500;
    localparam int FMAX         = 4000;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              abort = 1'b0;
    logic [FREQ_W-1:0] freq_out;
    logic              freq_upd;
    logic              busy;
    logic              locked;
    logic              cfg_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_freq;
    bit cur_locked;

    lo_tune_if #(.FREQ_W(FREQ_W), .STEP_W(STEP_W)) u_if ();

    lo_tune_ctrl #(
        .FREQ_W       (FREQ_W),
        .STEP_W       (STEP_W),
        .SETTLE_CYC   (SETTLE_CYC),
        .DEFAULT_FREQ (DEFAULT_FREQ),
        .FMIN         (FMIN),
        .FMAX         (FMAX)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_req      (u_if.slave),
        .i_abort    (abort),
        .o_freq_out (freq_out),
        .o_freq_upd (freq_upd),
        .o_busy     (busy),
        .o_locked   (locked),
        .o_cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected LO frequency k edges after an accept, derived from the slew rule.
    function automatic int traj(input int start, input int tgt, input int s, input int k);
        int v;
        if (k <= 0) return start;
        if (s == 0 || start == tgt) return tgt;
        if (tgt > start) begin
            v = start + k * s;
            return (v > tgt) ? tgt : v;
        end
        v = start - k * s;
        return (v < tgt) ? tgt : v;
    endfunction

    function automatic int clamp_tgt(input int f);
`ifdef LO_TUNE_CLAMP_EN
        if (f < FMIN) return FMIN;
        if (f > FMAX) return FMAX;
`endif
        return f;
    endfunction

    task automatic check_quiet(input string tag, input int f, input bit lk);
        check_eq({tag, "_freq"},  freq_out, f);
        check_eq({tag, "_upd"},   freq_upd, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_lock"},  locked, lk);
        check_eq({tag, "_ready"}, u_if.req_ready, 1);
        check_eq({tag, "_cfg"},   cfg_err, 0);
    endtask

    // abort_at = k asserts abort in the cycle ending at the k-th edge after accept.
    task automatic run_req(input int f, input int s, input int abort_at, input bit abort_with_req);
        int tgt, diff, n, total, start;
        bit hit;
        start = cur_freq;
        tgt   = clamp_tgt(f);
        hit   = (tgt != f);
        diff  = (tgt > start) ? tgt - start : start - tgt;
        n     = (s == 0 || diff == 0) ? 1 : (diff + s - 1) / s;
        total = n + SETTLE_CYC + 1;

        check_eq("ready_pre", u_if.req_ready, 1);
        u_if.req_valid = 1'b1;
        u_if.req_freq  = f[FREQ_W-1:0];
        u_if.req_step  = s[STEP_W-1:0];
        abort          = abort_with_req;
        @(posedge clk); #1;
        u_if.req_valid = 1'b0;
        abort          = 1'b0;
        check_eq("acc_freq",  freq_out, start);
        check_eq("acc_upd",   freq_upd, 0);
        check_eq("acc_busy",  busy, 1);
        check_eq("acc_lock",  locked, 0);
        check_eq("acc_ready", u_if.req_ready, 0);
        check_eq("acc_cfg",   cfg_err, hit);

        for (int k = 1; k <= total; k++) begin
            if (k == abort_at) abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            if (k == abort_at) begin
                cur_freq   = traj(start, tgt, s, k - 1);
                cur_locked = 1'b0;
                check_quiet("abort", cur_freq, 0);
                return;
            end
            check_eq("r_freq",  freq_out, traj(start, tgt, s, k));
            check_eq("r_upd",   freq_upd, (k <= n && diff != 0));
            check_eq("r_busy",  busy, (k < total));
            check_eq("r_lock",  locked, (k == total));
            check_eq("r_ready", u_if.req_ready, (k == total));
            check_eq("r_cfg",   cfg_err, 0);
        end
        cur_freq   = tgt;
        cur_locked = 1'b1;
    endtask

    initial begin
        int f, s, ab;
        u_if.req_valid = 1'b0;
        u_if.req_freq  = '0;
        u_if.req_step  = '0;
        cur_freq       = DEFAULT_FREQ;
        cur_locked     = 1'b0;

        #12;
        check_quiet("in_rst", DEFAULT_FREQ, 0);
        #11 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check_quiet("idle", DEFAULT_FREQ, 0);
        end

        run_req(2500, 100, 0, 0);
        run_req(1950, 100, 0, 0);
        run_req(3000, 0, 0, 0);
        run_req(3000, 0, 0, 0);
        run_req(2000, 0, 0, 0);
        run_req(2500, 100, 4, 0);
        check_eq("abort_2300", cur_freq, 2300);
        run_req(2600, 50, 0, 1);
        run_req(5000, 0, 0, 0);
        run_req(100, 300, 0, 0);
        run_req(3000, 700, 20, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       f = $urandom_range(0, 300);
                1:       f = 65535 - $urandom_range(0, 300);
                default: f = $urandom_range(0, 65535);
            endcase
            s  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(200, 4095);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
            run_req(f, s, ab, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                abort = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                abort = 1'b0;
                check_quiet("hold", cur_freq, cur_locked);
            end
        end

        // Asynchronous reset landing between clock edges in the middle of a ramp.
        u_if.req_valid = 1'b1;
        u_if.req_freq  = 16'(cur_freq > 30000 ? 1000 : 60000);
        u_if.req_step  = 12'd200;
        @(posedge clk); #1;
        u_if.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_quiet("async_rst", DEFAULT_FREQ, 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        cur_freq   = DEFAULT_FREQ;
        cur_locked = 1'b0;
        check_quiet("post_rst", DEFAULT_FREQ, 0);
        run_req(2100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
